pipeline_tracker: RTL and testbench

- Parametrised, synthesizable instruction-lifetime tracker for NUM_STAGES-deep CPU pipelines, for both simulation and on-chip debug.
- Tags each fetched instruction with a sequential ID and carries the ID plus a per-stage entry-cycle stamp through a shadow pipeline.
- Follows the CPU's per-stage stall/flush controls and pushes one retire record per completed instruction into an output FIFO drained by a valid/ready handshake.
- Keeps retired, flushed and dropped-record counters.

---
 rtl/pipeline_tracker.sv | 132 +++++++++++++
 tb/tb_pipeline_tracker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_tracker.sv
// pipeline_tracker: shadows a CPU pipeline and tags each instruction with an ID and per-stage entry stamps; emits one retire record per completed instruction
module pipeline_tracker #(
  parameter int NUM_STAGES  = 5,
  parameter int ID_W        = 8,
  parameter int CYC_W       = 16,
  parameter int RFIFO_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fetch_valid,
  output logic                        fetch_ready,
  input  logic [NUM_STAGES-1:0]       stall,
  input  logic [NUM_STAGES-1:0]       flush,
  output logic                        ret_valid,
  input  logic                        ret_ready,
  output logic [ID_W-1:0]             ret_id,
  output logic [NUM_STAGES*CYC_W-1:0] ret_stamps,
  output logic [$clog2(NUM_STAGES+1)-1:0] in_flight,
  output logic [CNT_W-1:0]            retired_cnt,
  output logic [CNT_W-1:0]            flushed_cnt,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        overflow
);
  localparam int IFW = $clog2(NUM_STAGES + 1);
  localparam int AW  = $clog2(RFIFO_DEPTH);
  typedef logic [NUM_STAGES-1:0][CYC_W-1:0] stamps_t;

  logic [CYC_W-1:0]      cyc;
  logic [ID_W-1:0]       next_id;
  logic [NUM_STAGES-1:0] v, hold, in_v;
  logic [ID_W-1:0]       id    [NUM_STAGES];
  stamps_t               st    [NUM_STAGES];
  logic [ID_W-1:0]       in_id [NUM_STAGES];
  stamps_t               in_st [NUM_STAGES];
  logic [ID_W-1:0]       mem_id [RFIFO_DEPTH];
  stamps_t               mem_st [RFIFO_DEPTH];
  logic [AW-1:0]         wp, rp;
  logic [AW:0]           cnt;
  logic                  push, pop, wr, full;
  logic [IFW-1:0]        kills;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // hold[s] is the OR of this and every later stall; each stage's candidate entry comes from the stage before it (or the fetch port)
  always_comb begin
    hold = '0;
    in_v = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      hold[s] = |(stall >> s);
    end
    in_v[0] = fetch_valid && !hold[0];
    in_id[0] = next_id;
    in_st[0] = '0;
    in_st[0][0] = cyc;
    for (int s = 1; s < NUM_STAGES; s++) begin
      in_v[s] = v[s-1] && !flush[s-1] && !hold[s-1];
      in_id[s] = id[s-1];
      in_st[s] = st[s-1];
      in_st[s][s] = cyc;
    end
  end

  assign fetch_ready = !hold[0];
  assign push  = v[NUM_STAGES-1] && !flush[NUM_STAGES-1] && !hold[NUM_STAGES-1];
  assign full  = cnt == (AW+1)'(RFIFO_DEPTH);
  assign pop   = ret_valid && ret_ready;
  assign wr    = push && (!full || pop);
  assign kills = IFW'($countones(v & flush));
  assign in_flight  = IFW'($countones(v));
  assign ret_valid  = cnt != '0;
  assign ret_id     = ret_valid ? mem_id[rp] : '0;
  assign ret_stamps = ret_valid ? mem_st[rp] : '0;

  // shadow stages: a held stage keeps its entry unless flushed; an unheld stage takes its candidate (a bubble if none)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      cyc <= '0;
      next_id <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        id[s] <= '0;
        st[s] <= '0;
      end
    end else begin
      cyc <= cyc + CYC_W'(1);
      if (in_v[0]) next_id <= next_id + ID_W'(1);
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (!hold[s]) begin
          v[s] <= in_v[s];
          id[s] <= in_id[s];
          st[s] <= in_st[s];
        end else if (flush[s]) v[s] <= 1'b0;
      end
    end
  end

  // retire FIFO pointers, occupancy and statistics; a pop frees a slot for a same-edge push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      retired_cnt <= '0;
      flushed_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      retired_cnt <= sat_add(retired_cnt, CNT_W'(wr));
      flushed_cnt <= sat_add(flushed_cnt, CNT_W'(kills));
      if (push && !wr) begin
        drop_cnt <= sat_add(drop_cnt, CNT_W'(1));
        overflow <= 1'b1;
      end
    end
  end

  // record storage needs no reset: reads are gated by ret_valid
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_id[wp] <= id[NUM_STAGES-1];
      mem_st[wp] <= st[NUM_STAGES-1];
    end
  end
endmodule

// File: tb/tb_pipeline_tracker.sv
// tb_pipeline_tracker: random stimulus checked against a queue-based reference model
module tb_pipeline_tracker;
  localparam int N = 5, IW = 8, CW = 16, D = 4, KW = 32, FW = $clog2(N + 1);
  localparam longint SAT = (64'd1 << KW) - 1;

  logic clk = 0, rst_n = 0, fetch_valid = 0, ret_ready = 0;
  logic [N-1:0] stall = '0, flush = '0;
  logic fetch_ready, ret_valid, overflow;
  logic [IW-1:0] ret_id;
  logic [N*CW-1:0] ret_stamps;
  logic [FW-1:0] in_flight;
  logic [KW-1:0] retired_cnt, flushed_cnt, drop_cnt;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipeline_tracker #(.NUM_STAGES(N), .ID_W(IW), .CYC_W(CW), .RFIFO_DEPTH(D), .CNT_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .stall(stall), .flush(flush), .ret_valid(ret_valid), .ret_ready(ret_ready),
    .ret_id(ret_id), .ret_stamps(ret_stamps), .in_flight(in_flight),
    .retired_cnt(retired_cnt), .flushed_cnt(flushed_cnt), .drop_cnt(drop_cnt), .overflow(overflow));

  typedef struct packed {logic [IW-1:0] id; logic [N*CW-1:0] st;} rec_t;
  rec_t q[$];
  rec_t me[N];
  bit mv[N];
  logic [CW-1:0] mcyc;
  logic [IW-1:0] mnid;
  longint mret, mfl, mdrop;
  bit movf;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x);
    return x > SAT ? SAT : x;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int s = 0; s < N; s++) begin
      mv[s] = 0;
      me[s] = '0;
    end
    mcyc = 0; mnid = 0; mret = 0; mfl = 0; mdrop = 0; movf = 0;
  endtask

  task automatic model_step();
    bit h[N];
    bit nv[N];
    rec_t ne[N];
    bit pop, push;
    int kills;
    kills = 0;
    for (int s = 0; s < N; s++) begin
      h[s] = 0;
      for (int k = s; k < N; k++) if (stall[k]) h[s] = 1;
      if (mv[s] && flush[s]) kills++;
    end
    pop = q.size() != 0 && ret_ready;
    push = mv[N-1] && !flush[N-1] && !h[N-1];
    for (int s = 0; s < N; s++) begin
      if (h[s]) begin
        nv[s] = mv[s] && !flush[s];
        ne[s] = me[s];
      end else if (s == 0) begin
        nv[0] = fetch_valid;
        ne[0].id = mnid;
        ne[0].st = '0;
        ne[0].st[CW-1:0] = mcyc;
      end else begin
        nv[s] = mv[s-1] && !flush[s-1] && !h[s-1];
        ne[s] = me[s-1];
        ne[s].st[s*CW +: CW] = mcyc;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < D) begin
        q.push_back(me[N-1]);
        mret = sat(mret + 1);
      end else begin
        mdrop = sat(mdrop + 1);
        movf = 1;
      end
    end
    mfl = sat(mfl + kills);
    if (fetch_valid && !h[0]) mnid++;
    mcyc++;
    for (int s = 0; s < N; s++) begin
      mv[s] = nv[s];
      me[s] = ne[s];
    end
  endtask

  task automatic check_all();
    int nf;
    nf = 0;
    for (int s = 0; s < N; s++) nf += int'(mv[s]);
    chk("fetch_ready", fetch_ready, !(|stall));
    chk("ret_valid", ret_valid, q.size() != 0);
    chk("ret_id", ret_id, q.size() != 0 ? q[0].id : '0);
    chk("ret_stamps", ret_stamps, q.size() != 0 ? q[0].st : '0);
    chk("in_flight", in_flight, nf);
    chk("retired_cnt", retired_cnt, mret);
    chk("flushed_cnt", flushed_cnt, mfl);
    chk("drop_cnt", drop_cnt, mdrop);
    chk("overflow", overflow, movf);
  endtask

  function automatic logic [N-1:0] rvec(input int pct);
    logic [N-1:0] r;
    for (int s = 0; s < N; s++) r[s] = $urandom_range(0, 99) < pct;
    return r;
  endfunction

  // called at a negedge: check current state, then drive the inputs for the next edge
  task automatic cycle(input bit fv, input logic [N-1:0] st_in, input logic [N-1:0] fl_in, input bit rr);
    check_all();
    fetch_valid = fv; stall = st_in; flush = fl_in; ret_ready = rr;
    model_step();
    @(negedge clk);
  endtask

  task automatic phase(input int cycles, input int pf, input int ps, input int pfl, input int pr);
    for (int i = 0; i < cycles; i++)
      cycle($urandom_range(0, 99) < pf, rvec(ps), rvec(pfl), $urandom_range(0, 99) < pr);
  endtask

  initial begin
    logic [N*CW-1:0] lat;
    for (int k = 0; k < N; k++) lat[k*CW +: CW] = CW'(2 + k);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) chk("lat_not_yet", ret_valid, 1'b0);
      if (i == 8) begin
        chk("lat_valid", ret_valid, 1'b1);
        chk("lat_id0", ret_id, '0);
        chk("lat_stamps", ret_stamps, lat);
      end
      cycle(i >= 2 && i < 5, '0, '0, 1'b1);
    end
    phase(300, 90, 0, 0, 100);
    phase(300, 80, 8, 0, 90);
    phase(300, 80, 5, 8, 90);
    phase(200, 95, 0, 0, 5);
    phase(400, 70, 10, 10, 60);
    rst_n = 0;
    fetch_valid = 0; stall = '0; flush = '0; ret_ready = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1;
    cycle(1'b1, '0, '0, 1'b1);
    chk("post_rst_stage0", dut.in_flight, 1);
    phase(400, 75, 10, 10, 70);
    phase(200, 90, 3, 3, 10);
    check_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
